mips_debug_sequencer: RTL and testbench

//  Command-driven debug controller between a host word stream and top_mips.

---
 rtl/mips_debug_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_mips_debug_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_sequencer.sv
// Host-driven debug controller for top_mips: program load, run/step/reset control,
// and a streamed dump of PC, cycle count and the register file.
module mips_debug_sequencer #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 32,
  parameter int NB_REG     = 5,
  parameter int N_REGS     = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int RST_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic               o_rx_ready,
  output logic               o_imem_write,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic               o_cpu_enable,
  output logic               o_cpu_reset,
  input  logic               i_halt,
  input  logic [NB_ADDR-1:0] i_pc,
  output logic [NB_REG-1:0]  o_rf_addr,
  input  logic [NB_DATA-1:0] i_rf_data,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic               o_error
);

  typedef enum logic [2:0] {IDLE, LOAD_LEN, LOAD_WORDS, RUN, STEP, DUMP, CPU_RST} state_t;

  localparam int IDX_W = $clog2(N_REGS + 2);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_REGS + 1);
  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [NB_DATA-1:0] MAX_LEN  = NB_DATA'(IMEM_DEPTH);

  state_t             state_reg, state_next;
  logic [NB_DATA-1:0] word_cnt_reg, word_cnt_next;
  logic [NB_DATA-1:0] len_reg, len_next;
  logic [31:0]        cycle_cnt_reg, cycle_cnt_next, cycle_inc;
  logic [RST_W-1:0]   rst_cnt_reg, rst_cnt_next;
  logic [IDX_W-1:0]   beat_idx_reg, beat_idx_next;
  logic [1:0]         rf_wait_reg, rf_wait_next;
  logic               rx_ready_reg, rx_ready_next;
  logic               imem_write_reg, imem_write_next;
  logic [NB_ADDR-1:0] imem_addr_reg, imem_addr_next;
  logic [NB_DATA-1:0] imem_data_reg, imem_data_next;
  logic               cpu_enable_reg, cpu_enable_next;
  logic               cpu_reset_reg, cpu_reset_next;
  logic [NB_REG-1:0]  rf_addr_reg, rf_addr_next;
  logic               dump_valid_reg, dump_valid_next;
  logic [NB_DATA-1:0] dump_data_reg, dump_data_next;
  logic               dump_last_reg, dump_last_next;
  logic               error_reg, error_next;

  logic rx_fire, dump_fire;
  assign rx_fire   = i_rx_valid && rx_ready_reg;
  assign dump_fire = dump_valid_reg && i_dump_ready;
  assign cycle_inc = (cycle_cnt_reg == '1) ? cycle_cnt_reg : cycle_cnt_reg + 32'd1;

  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    len_next        = len_reg;
    cycle_cnt_next  = cycle_cnt_reg;
    rst_cnt_next    = rst_cnt_reg;
    beat_idx_next   = beat_idx_reg;
    rf_wait_next    = rf_wait_reg;
    imem_write_next = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_data_next  = imem_data_reg;
    rf_addr_next    = rf_addr_reg;
    dump_valid_next = dump_valid_reg;
    dump_data_next  = dump_data_reg;
    dump_last_next  = dump_last_reg;
    error_next      = 1'b0;

    case (state_reg)
      IDLE: if (rx_fire) begin
        case (i_rx_data[7:0])
          8'h01: state_next = LOAD_LEN;
          8'h02: begin state_next = RUN; cycle_cnt_next = '0; end
          8'h03: state_next = STEP;
          8'h04: state_next = DUMP;
          8'h05: begin state_next = CPU_RST; rst_cnt_next = '0; cycle_cnt_next = '0; end
          default: error_next = 1'b1;
        endcase
      end
      LOAD_LEN: if (rx_fire) begin
        if (i_rx_data == '0 || i_rx_data > MAX_LEN) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          len_next      = i_rx_data;
          word_cnt_next = '0;
          state_next    = LOAD_WORDS;
        end
      end
      LOAD_WORDS: if (rx_fire) begin
        imem_write_next = 1'b1;
        imem_addr_next  = NB_ADDR'(word_cnt_reg);
        imem_data_next  = i_rx_data;
        word_cnt_next   = word_cnt_reg + NB_DATA'(1);
        if (word_cnt_reg == len_reg - NB_DATA'(1)) state_next = IDLE;
      end
      RUN: begin
        cycle_cnt_next = cycle_inc;
        if (i_halt) state_next = DUMP;
      end
      STEP: begin
        cycle_cnt_next = cycle_inc;
        state_next     = DUMP;
      end
      DUMP: begin
        // Register beats: address out, one cycle for the read, then capture.
        if (rf_wait_reg == 2'd2) begin
          rf_wait_next = 2'd1;
        end else if (rf_wait_reg == 2'd1) begin
          rf_wait_next    = 2'd0;
          dump_valid_next = 1'b1;
          dump_data_next  = i_rf_data;
          dump_last_next  = (beat_idx_reg == LAST_IDX);
        end else if (dump_fire) begin
          if (dump_last_reg) begin
            dump_valid_next = 1'b0;
            dump_last_next  = 1'b0;
            state_next      = IDLE;
          end else if (beat_idx_reg == '0) begin
            dump_data_next = NB_DATA'(cycle_cnt_reg);
            beat_idx_next  = IDX_W'(1);
          end else begin
            dump_valid_next = 1'b0;
            rf_addr_next    = NB_REG'(beat_idx_reg - IDX_W'(1));
            rf_wait_next    = 2'd2;
            beat_idx_next   = beat_idx_reg + IDX_W'(1);
          end
        end
      end
      CPU_RST: begin
        if (rst_cnt_reg == RST_LAST) state_next = IDLE;
        else rst_cnt_next = rst_cnt_reg + RST_W'(1);
      end
      default: state_next = IDLE;
    endcase

    // Entering DUMP presents the PC beat straight away.
    if (state_next == DUMP && state_reg != DUMP) begin
      dump_valid_next = 1'b1;
      dump_data_next  = NB_DATA'(i_pc);
      dump_last_next  = 1'b0;
      beat_idx_next   = '0;
      rf_wait_next    = 2'd0;
    end

    rx_ready_next   = (state_next == IDLE) || (state_next == LOAD_LEN) || (state_next == LOAD_WORDS);
    cpu_enable_next = (state_next == RUN) || (state_next == STEP);
    cpu_reset_next  = (state_next == CPU_RST);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      word_cnt_reg   <= '0;
      len_reg        <= '0;
      cycle_cnt_reg  <= '0;
      rst_cnt_reg    <= '0;
      beat_idx_reg   <= '0;
      rf_wait_reg    <= '0;
      rx_ready_reg   <= 1'b0;
      imem_write_reg <= 1'b0;
      imem_addr_reg  <= '0;
      imem_data_reg  <= '0;
      cpu_enable_reg <= 1'b0;
      cpu_reset_reg  <= 1'b0;
      rf_addr_reg    <= '0;
      dump_valid_reg <= 1'b0;
      dump_data_reg  <= '0;
      dump_last_reg  <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      len_reg        <= len_next;
      cycle_cnt_reg  <= cycle_cnt_next;
      rst_cnt_reg    <= rst_cnt_next;
      beat_idx_reg   <= beat_idx_next;
      rf_wait_reg    <= rf_wait_next;
      rx_ready_reg   <= rx_ready_next;
      imem_write_reg <= imem_write_next;
      imem_addr_reg  <= imem_addr_next;
      imem_data_reg  <= imem_data_next;
      cpu_enable_reg <= cpu_enable_next;
      cpu_reset_reg  <= cpu_reset_next;
      rf_addr_reg    <= rf_addr_next;
      dump_valid_reg <= dump_valid_next;
      dump_data_reg  <= dump_data_next;
      dump_last_reg  <= dump_last_next;
      error_reg      <= error_next;
    end
  end

  assign o_rx_ready   = rx_ready_reg;
  assign o_imem_write = imem_write_reg;
  assign o_imem_addr  = imem_addr_reg;
  assign o_imem_data  = imem_data_reg;
  assign o_cpu_enable = cpu_enable_reg;
  assign o_cpu_reset  = cpu_reset_reg;
  assign o_rf_addr    = rf_addr_reg;
  assign o_dump_valid = dump_valid_reg;
  assign o_dump_data  = dump_data_reg;
  assign o_dump_last  = dump_last_reg;
  assign o_error      = error_reg;

endmodule

// File: tb/tb_mips_debug_sequencer.sv
// Scoreboard bench for mips_debug_sequencer with a stub CPU (halts after 5 enabled
// cycles, PC = 0x1000 + 4*enabled cycles) and a register file that returns its index.
module tb_mips_debug_sequencer;
  localparam int IMEM_DEPTH = 256;
  localparam int N_REGS     = 32;

  logic        i_clk = 1'b0;
  logic        i_reset, i_rx_valid, i_halt, i_dump_ready;
  logic [31:0] i_rx_data, i_pc, i_rf_data;
  logic        o_rx_ready, o_imem_write, o_cpu_enable, o_cpu_reset;
  logic        o_dump_valid, o_dump_last, o_error;
  logic [31:0] o_imem_addr, o_imem_data, o_dump_data;
  logic [4:0]  o_rf_addr;

  mips_debug_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_ready(o_rx_ready), .o_imem_write(o_imem_write), .o_imem_addr(o_imem_addr),
    .o_imem_data(o_imem_data), .o_cpu_enable(o_cpu_enable), .o_cpu_reset(o_cpu_reset),
    .i_halt(i_halt), .i_pc(i_pc), .o_rf_addr(o_rf_addr), .i_rf_data(i_rf_data),
    .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .o_dump_last(o_dump_last),
    .i_dump_ready(i_dump_ready), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Stub CPU and register file
  logic [7:0]  run_cnt, pc_cnt;
  logic [31:0] rf_q;
  always @(posedge i_clk) begin
    if (i_reset || o_cpu_reset) begin
      run_cnt <= 8'd0;
      pc_cnt  <= 8'd0;
    end else begin
      run_cnt <= o_cpu_enable ? run_cnt + 8'd1 : 8'd0;
      if (o_cpu_enable) pc_cnt <= pc_cnt + 8'd1;
    end
    rf_q <= 32'(o_rf_addr);
  end
  assign i_halt    = o_cpu_enable && (run_cnt >= 8'd4);
  assign i_pc      = 32'h1000 + {22'd0, pc_cnt, 2'b00};
  assign i_rf_data = rf_q;

  int checks = 0;
  int errors = 0;
  logic [63:0] imem_q[$];
  logic [32:0] dump_q[$];
  int          en_q[$];
  int          rst_q[$];
  bit          err_q[$];
  int          beats_done = 0;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_ready"},   64'(o_rx_ready),   64'd0);
    check({tag, "_imem_write"}, 64'(o_imem_write), 64'd0);
    check({tag, "_imem_addr"},  64'(o_imem_addr),  64'd0);
    check({tag, "_imem_data"},  64'(o_imem_data),  64'd0);
    check({tag, "_cpu_enable"}, 64'(o_cpu_enable), 64'd0);
    check({tag, "_cpu_reset"},  64'(o_cpu_reset),  64'd0);
    check({tag, "_rf_addr"},    64'(o_rf_addr),    64'd0);
    check({tag, "_dump_valid"}, 64'(o_dump_valid), 64'd0);
    check({tag, "_dump_data"},  64'(o_dump_data),  64'd0);
    check({tag, "_dump_last"},  64'(o_dump_last),  64'd0);
    check({tag, "_error"},      64'(o_error),      64'd0);
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b1;
    i_rx_data  = w;
    while (1) begin
      @(negedge i_clk);
      if (o_rx_ready) break;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL rx_timeout: word %0h not accepted, required acceptance", w);
        break;
      end
    end
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cnt);
    dump_q.push_back({1'b0, pc});
    dump_q.push_back({1'b0, cnt});
    for (int k = 0; k < N_REGS; k++) dump_q.push_back({(k == N_REGS - 1), 32'(k)});
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (dump_q.size() != 0 || en_q.size() != 0) begin
      @(posedge i_clk); #1;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s_timeout: %0d beats pending, required 0", tag, dump_q.size());
        break;
      end
    end
  endtask

  // Sink-ready driver
  initial begin
    i_dump_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      i_dump_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples mid-cycle and pops the scoreboard queues
  int          en_len = 0, rst_len = 0, exp_len;
  logic [63:0] exp_w;
  logic [32:0] exp_b;
  bit          prev_stall = 1'b0, prev_last;
  logic [31:0] prev_data;
  logic [4:0]  prev_addr;
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_imem_write) begin
        $display("imem write addr %0d data %h", o_imem_addr, o_imem_data);
        if (imem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL imem_unexpected: write addr %0h, required none", o_imem_addr);
        end else begin
          exp_w = imem_q.pop_front();
          check("imem_write", {o_imem_addr, o_imem_data}, exp_w);
        end
      end
      if (o_error) begin
        $display("error pulse");
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL error_unexpected: o_error 1, required 0");
        end else begin
          void'(err_q.pop_front());
          checks++;
        end
      end
      if (i_reset) begin
        en_len = 0; rst_len = 0; prev_stall = 1'b0;
      end else begin
        if (o_cpu_enable) en_len++;
        else if (en_len > 0) begin
          exp_len = (en_q.size() != 0) ? en_q.pop_front() : -1;
          $display("enable burst %0d cycles", en_len);
          check("enable_len", 64'(en_len), 64'(exp_len));
          en_len = 0;
        end
        if (o_cpu_reset) rst_len++;
        else if (rst_len > 0) begin
          exp_len = (rst_q.size() != 0) ? rst_q.pop_front() : -1;
          $display("cpu reset burst %0d cycles", rst_len);
          check("cpu_reset_len", 64'(rst_len), 64'(exp_len));
          rst_len = 0;
        end
        if (prev_stall)
          check("dump_hold", {o_dump_valid, o_dump_last, o_rf_addr, o_dump_data},
                {1'b1, prev_last, prev_addr, prev_data});
        if (o_dump_valid && i_dump_ready) begin
          $display("dump beat data %h last %0d", o_dump_data, o_dump_last);
          beats_done++;
          if (dump_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dump_unexpected: beat %h, required none", o_dump_data);
          end else begin
            exp_b = dump_q.pop_front();
            check("dump_beat", {o_dump_last, o_dump_data}, exp_b);
          end
        end
        prev_stall = o_dump_valid && !i_dump_ready;
        prev_last  = o_dump_last;
        prev_data  = o_dump_data;
        prev_addr  = o_rf_addr;
      end
    end
  end

  int start, n;
  initial begin
    i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero("reset");
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    check("ready_idle", 64'(o_rx_ready), 64'd1);

    // Program load of three words
    imem_q.push_back({32'd0, 32'h00232020});
    imem_q.push_back({32'd1, 32'h00000000});
    imem_q.push_back({32'd2, 32'h00000000});
    send(32'h1); send(32'd3); send(32'h00232020); send(32'h0); send(32'h0);

    // Bad lengths and a bad command
    err_q.push_back(1'b1); send(32'h1); send(32'd0);
    err_q.push_back(1'b1); send(32'h1); send(32'(IMEM_DEPTH + 1));
    err_q.push_back(1'b1); send(32'h000000A7);

    // RUN with a randomly stalling sink
    rand_mode = 1'b1;
    en_q.push_back(5); push_dump(32'h1010, 32'd5);
    send(32'h2); wait_drain("run");

    // CPU reset clears the counter, then a single step
    rst_q.push_back(4); send(32'h5);
    en_q.push_back(1); push_dump(32'h1000, 32'd1);
    send(32'h3); wait_drain("step");
    rand_mode = 1'b0;

    // Reset while word 2 of 4 is offered
    imem_q.push_back({32'd0, 32'h11111111});
    imem_q.push_back({32'd1, 32'h22222222});
    send(32'h1); send(32'd4); send(32'h11111111); send(32'h22222222);
    i_rx_valid = 1'b1; i_rx_data = 32'h33333333; i_reset = 1'b1;
    @(posedge i_clk); #1;
    check_zero("load_abort");
    i_reset = 1'b0; i_rx_valid = 1'b0;

    // Reset after dump beat 10
    en_q.push_back(5); push_dump(32'h1010, 32'd5);
    start = beats_done;
    send(32'h2);
    n = 0;
    while (beats_done - start < 10) begin
      @(posedge i_clk); #1;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL dump10_timeout: %0d beats, required 10", beats_done - start);
        break;
      end
    end
    i_reset = 1'b1;
    dump_q.delete();
    @(posedge i_clk); #1;
    check_zero("dump_abort");
    i_reset = 1'b0;

    // Fresh RUN after the abort
    en_q.push_back(5); push_dump(32'h1010, 32'd5);
    send(32'h2); wait_drain("run2");

    repeat (5) @(posedge i_clk);
    #1;
    check("imem_q_empty", 64'(imem_q.size()), 64'd0);
    check("dump_q_empty", 64'(dump_q.size()), 64'd0);
    check("en_q_empty",   64'(en_q.size()),   64'd0);
    check("rst_q_empty",  64'(rst_q.size()),  64'd0);
    check("err_q_empty",  64'(err_q.size()),  64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
